// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with fetch-ahead pixel port.
// Counters -> request stage -> LATENCY-deep display pipe -> DAC pin registers.
module vga_timing_gen #(
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int LATENCY = 2,
  parameter int CW      = 8,
  parameter int XW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  output logic          req,
  output logic [XW-1:0] x,
  output logic [XW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic          vga_sync_n
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] V_LAST = XW'(V_TOTAL - 1);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  typedef enum logic [1:0] {
    PH_ACT,
    PH_FP,
    PH_SYNC,
    PH_BP
  } ph_e;

  // Empty porches are skipped; sync is assumed non-empty.
  function automatic ph_e ph_nxt(ph_e p, int fp, int bp);
    ph_e n;
    n = PH_ACT;
    unique case (p)
      PH_ACT:  n = (fp > 0) ? PH_FP : PH_SYNC;
      PH_FP:   n = PH_SYNC;
      PH_SYNC: n = (bp > 0) ? PH_BP : PH_ACT;
      default: n = PH_ACT;
    endcase
    return n;
  endfunction

  function automatic logic [XW-1:0] ph_end(
    ph_e p, int act, int fp, int sy, int bp
  );
    int e;
    e = 0;
    unique case (p)
      PH_ACT:  e = act;
      PH_FP:   e = act + fp;
      PH_SYNC: e = act + fp + sy;
      default: e = act + fp + sy + bp;
    endcase
    return XW'(e - 1);
  endfunction

  logic [XW-1:0] h_cnt_q, v_cnt_q;
  ph_e           h_ph_q, v_ph_q;
  logic          h_wrap, v_wrap;
  logic          h_bnd, v_bnd;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);
  assign h_bnd  = (h_cnt_q ==
                   ph_end(h_ph_q, H_ACT, H_FP, H_SYNC, H_BP));
  assign v_bnd  = (v_cnt_q ==
                   ph_end(v_ph_q, V_ACT, V_FP, V_SYNC, V_BP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_ph_q  <= PH_ACT;
      v_ph_q  <= PH_ACT;
    end else if (!en) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_ph_q  <= PH_ACT;
      v_ph_q  <= PH_ACT;
    end else begin
      h_cnt_q <= h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_bnd) h_ph_q <= ph_nxt(h_ph_q, H_FP, H_BP);
      if (h_wrap) begin
        v_cnt_q <= v_wrap ? '0 : v_cnt_q + 1'b1;
        if (v_bnd) v_ph_q <= ph_nxt(v_ph_q, V_FP, V_BP);
      end
    end
  end

  logic h_act, v_act;
  assign h_act = (h_ph_q == PH_ACT);
  assign v_act = (v_ph_q == PH_ACT);

  logic          req_q, ls_q, fs_q, vbl_q;
  logic          hs0_q, vs0_q;
  logic [XW-1:0] x_q, y_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      vbl_q <= 1'b1;
      hs0_q <= 1'b0;
      vs0_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (!en) begin
      req_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      vbl_q <= 1'b1;
      hs0_q <= 1'b0;
      vs0_q <= 1'b0;
    end else begin
      req_q <= h_act & v_act;
      ls_q  <= h_act & v_act & (h_cnt_q == '0);
      fs_q  <= h_act & v_act & (h_cnt_q == '0)
               & (v_cnt_q == '0);
      vbl_q <= ~v_act;
      hs0_q <= (h_ph_q == PH_SYNC);
      vs0_q <= (v_ph_q == PH_SYNC);
      if (h_act) x_q <= h_cnt_q;
      if (v_act) y_q <= v_cnt_q;
    end
  end

  // de/hs/vs travel together so syncs stay aligned with pixel data.
  logic de_d, hs_d, vs_d;

  if (LATENCY == 0) begin : g_nodly
    assign de_d = req_q;
    assign hs_d = hs0_q;
    assign vs_d = vs0_q;
  end else begin : g_dly
    logic [2:0] sr_q [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < LATENCY; i++) sr_q[i] <= 3'b000;
      end else begin
        sr_q[0] <= {req_q, hs0_q, vs0_q};
        for (int i = 1; i < LATENCY; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign de_d = sr_q[LATENCY-1][2];
    assign hs_d = sr_q[LATENCY-1][1];
    assign vs_d = sr_q[LATENCY-1][0];
  end

  logic [CW-1:0] vr_q, vg_q, vb_q;
  logic          vhs_q, vvs_q, vbn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vr_q  <= '0;
      vg_q  <= '0;
      vb_q  <= '0;
      vbn_q <= 1'b0;
      vhs_q <= ~HS_ON;
      vvs_q <= ~VS_ON;
    end else begin
      vr_q  <= de_d ? r : '0;
      vg_q  <= de_d ? g : '0;
      vb_q  <= de_d ? b : '0;
      vbn_q <= de_d;
      vhs_q <= hs_d ? HS_ON : ~HS_ON;
      vvs_q <= vs_d ? VS_ON : ~VS_ON;
    end
  end

  assign req         = req_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign vblank      = vbl_q;
  assign vga_r       = vr_q;
  assign vga_g       = vg_q;
  assign vga_b       = vb_q;
  assign vga_hs      = vhs_q;
  assign vga_vs      = vvs_q;
  assign vga_blank_n = vbn_q;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two configs (LATENCY=2/HS_POL=0, LATENCY=0/HS_POL=1)
// against a raster-index reference model with a pin scoreboard.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HSW = 3;
  localparam int HB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VSW = 2;
  localparam int VB = 1;
  localparam int VT = VA + VF + VSW + VB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic de;
    logic hs;
    logic vs;
    int   x;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int   L   = (gi == 0) ? 2 : 0;
    localparam int   HP  = gi;
    localparam logic HON = (HP != 0);

    logic [7:0]  r = 8'd0;
    logic [7:0]  g = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        req, ls, fs, vbl, hs_o, vs_o, bl_n, sy_n;
    logic [11:0] x, y;
    logic [7:0]  vr, vg, vb;

    vga_timing_gen #(
      .H_ACT(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(HP), .VS_POL(0), .LATENCY(L), .CW(8), .XW(12)
    ) dut (
      .clk(clk), .rst(rst), .en(en),
      .r(r), .g(g), .b(b),
      .req(req), .x(x), .y(y),
      .line_start(ls), .frame_start(fs), .vblank(vbl),
      .vga_r(vr), .vga_g(vg), .vga_b(vb),
      .vga_hs(hs_o), .vga_vs(vs_o),
      .vga_blank_n(bl_n), .vga_sync_n(sy_n)
    );

    ent_t q[$];
    int   idx = 0;
    int   cyc = 0;
    logic e_req = 1'b0;
    logic e_ls  = 1'b0;
    logic e_fs  = 1'b0;
    logic e_vbl = 1'b1;
    int   e_x = 0;
    int   e_y = 0;
    logic [7:0] sr = 8'd0;
    logic [7:0] sg = 8'd0;
    logic [7:0] sb = 8'd0;

    // Reference: raster position is a linear index into the frame.
    always @(posedge clk or negedge rst) begin
      int   h, v;
      logic ha, va, hsy, vsy;
      if (!rst) begin
        idx = 0;
        q.delete();
        e_req = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_vbl = 1'b1;
        e_x = 0; e_y = 0;
        sr = 8'd0; sg = 8'd0; sb = 8'd0;
      end else begin
        cyc++;
        sr = r; sg = g; sb = b;
        h = idx % HT;
        v = idx / HT;
        ha  = en && (h < HA);
        va  = en && (v < VA);
        hsy = en && (h >= HA + HF) && (h < HA + HF + HSW);
        vsy = en && (v >= VA + VF) && (v < VA + VF + VSW);
        e_req = ha && va;
        e_ls  = e_req && (h == 0);
        e_fs  = e_ls && (v == 0);
        e_vbl = !va;
        if (ha) e_x = h;
        if (va) e_y = v;
        q.push_back('{cyc + L + 1, e_req, hsy, vsy, h});
        idx = en ? (idx + 1) % (HT * VT) : 0;
      end
    end

    // Monitor: compare request side and pop pin expectations.
    always @(negedge clk) begin
      ent_t p;
      logic de, hsa, vsa;
      de = 1'b0; hsa = 1'b0; vsa = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        p = q.pop_front();
        de = p.de; hsa = p.hs; vsa = p.vs;
      end
      chk($sformatf("c%0d req", gi), 32'(req), 32'(e_req));
      chk($sformatf("c%0d x", gi), 32'(x), 32'(e_x));
      chk($sformatf("c%0d y", gi), 32'(y), 32'(e_y));
      chk($sformatf("c%0d line_start", gi), 32'(ls), 32'(e_ls));
      chk($sformatf("c%0d frame_start", gi), 32'(fs), 32'(e_fs));
      chk($sformatf("c%0d vblank", gi), 32'(vbl), 32'(e_vbl));
      chk($sformatf("c%0d blank_n", gi), 32'(bl_n), 32'(de));
      chk($sformatf("c%0d vga_r", gi), 32'(vr), 32'(de ? sr : 8'd0));
      chk($sformatf("c%0d vga_g", gi), 32'(vg), 32'(de ? sg : 8'd0));
      chk($sformatf("c%0d vga_b", gi), 32'(vb), 32'(de ? sb : 8'd0));
      chk($sformatf("c%0d hs", gi), 32'(hs_o), 32'(hsa ? HON : !HON));
      chk($sformatf("c%0d vs", gi), 32'(vs_o), 32'(vsa ? 1'b0 : 1'b1));
      chk($sformatf("c%0d sync_n", gi), 32'(sy_n), 32'(1'b0));
      if (q.size() > 0 && q[0].due == cyc + 1 && q[0].de)
        r = 8'(q[0].x);
      else
        r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
    end

    // Reset must act without a clock edge.
    always @(negedge rst) begin
      #1;
      chk($sformatf("c%0d rst req", gi), 32'(req), 32'(1'b0));
      chk($sformatf("c%0d rst fs", gi), 32'(fs), 32'(1'b0));
      chk($sformatf("c%0d rst vblank", gi), 32'(vbl), 32'(1'b1));
      chk($sformatf("c%0d rst blank_n", gi), 32'(bl_n), 32'(1'b0));
      chk($sformatf("c%0d rst vga_r", gi), 32'(vr), 32'(8'd0));
      chk($sformatf("c%0d rst hs", gi), 32'(hs_o), 32'(!HON));
      chk($sformatf("c%0d rst vs", gi), 32'(vs_o), 32'(1'b1));
    end
  end

  initial begin
    en  = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // Stop with the request side at (3,2) of the third frame.
    repeat (34 + 2 * HT * VT) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(10, 250)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #2 rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b1;
      end else begin
        en = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        en = 1'b1;
      end
    end
    repeat (50) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
